param_alu_tx: RTL and testbench
===============================

PARAM_ALU_TX -- requirements
Module: param_alu_tx

Interface
REQ-001 Parameter WIDTH, default 4: operand width in bits; legal range 4..16.
REQ-002 Parameter FIFO_DEPTH, default 4: result FIFO entries; power of two, at least 2.
REQ-003 Parameter CLKS_PER_BIT, default 868: clk cycles per UART bit; at least 2.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 save_a_n  input  1  active-low; when sampled low, operand A is loaded from data_input.
REQ-007 save_b_n  input  1  active-low; when sampled low, operand B is loaded from data_input.
REQ-008 data_input  input  WIDTH  operand data.
REQ-009 op_select  input  4  operation code, sampled together with start.
REQ-010 start  input  1  one-cycle request: compute op(A,B) and enqueue the result.
REQ-011 uart_txd  output  1  serial line; idles high.
REQ-012 uart_busy  output  1  high while the FIFO is non-empty or a frame is in progress.
REQ-013 fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-014 overflow  output  1  sticky flag: a start was dropped.

Function
REQ-015 Both saves low in the same cycle: A and B both load.
- start in the same cycle as a save uses the pre-load operand values.
REQ-016 Result R is 2*WIDTH bits, zero-extended unless a code below says otherwise; W = WIDTH.
- 0 ADD: A+B, carry in bit W.
- 1 SUB: A-B mod 2^W, borrow in bit W.
- 2 MUL: A*B, full 2W-bit product.
- 3 AND, 4 OR, 5 XOR.
- 6 NOT: ~A.
- 7 SHL: A<<B mod 2^W; 8 SHR: A>>B logical; shift amount B >= W gives 0.
- 9 CMP: bit0 = A<B, bit1 = A==B, bit2 = A>B (unsigned).
- 10 INC: A+1, carry in bit W; 11 DEC: A-1 mod 2^W, borrow in bit W.
- 12-15: R = 0.
REQ-017 start with FIFO not full: R is written to the FIFO at that edge; fifo_empty is internal.
REQ-018 start with fifo_full high: request dropped, overflow set until reset.
- fullness is evaluated before any same-cycle pop, so a pop in that cycle does not rescue the request.
REQ-019 When the serializer is idle and the FIFO is non-empty, it pops the head entry.
- the first start bit appears on uart_txd on the cycle after the pop.
- a push to an empty idle FIFO therefore starts transmission 2 cycles after start.
REQ-020 Each result is sent as NB = ceil(2W/8) bytes, least-significant byte first; pad bits are 0.
- bytes follow back to back with no idle bits between them.
REQ-021 Frame per byte: start bit 0, 8 data bits LSB first, optional parity bit (REQ-026), stop bit 1.
- each bit is held exactly CLKS_PER_BIT cycles.
REQ-022 Serializer FSM states: IDLE, START, DATA, PARITY, STOP.
- STOP goes to START while result bytes remain.
- STOP goes to START of the next entry when the last byte is done and the FIFO is non-empty.
- otherwise STOP goes to IDLE.
REQ-023 uart_busy = (FSM != IDLE) or FIFO non-empty, registered.
- it drops on the cycle after the final stop bit of the last queued entry.

Reset
REQ-024 Reset values:
- uart_txd = 1.
- uart_busy, fifo_full, overflow = 0.
- A = B = 0.
- FIFO empty, FSM in IDLE, bit and baud counters = 0.
REQ-025 Reset asserted mid-frame aborts the frame; uart_txd is 1 on the following cycle.
- all queued results are discarded.
- start is ignored while reset is high.

Configuration
REQ-026 Macro PARAM_ALU_TX_PARITY_EN, when defined, inserts an even-parity bit after the data bits: 11-bit frame.
- when undefined, there is no PARITY state and the frame is 10 bits.

Structure
REQ-027 Package param_alu_tx_pkg holds:
- the op-code localparams (OP_ADD..OP_DEC);
- the serializer FSM state enum;
- the function computing NB from WIDTH.
REQ-028 Sub-module alu_uart_serializer (FIFO pop, byte sequencing, framing, baud counter).
- the ALU datapath and FIFO stay in param_alu_tx.

Verification
REQ-029 W=4, CLKS_PER_BIT=4: A=9, B=5, op 0, start -> one frame carrying 0x0E, 40 cycles long; uart_busy falls afterwards.
REQ-030 W=4: A=15, B=15, op 2 -> 0xE1; A=3, B=5, op 1 -> 0x1E; op 9 with A=B=7 -> 0x02.
REQ-031 W=12: A=0xFFF, B=0xFFF, op 2 -> three frames 0x01, 0xE0, 0xFF; four with 0xFF00? no: product 0xFFE001 sent 0x01, 0xE0, 0xFF in order.
REQ-032 W=4, FIFO_DEPTH=4: six back-to-back starts -> first entry popped, next four queued, sixth dropped.
- overflow = 1 and exactly five frames are transmitted.
REQ-033 Reset pulse mid-data-bit -> uart_txd = 1 and uart_busy = 0 next cycle; no further frames.
REQ-034 With PARAM_ALU_TX_PARITY_EN: result 0x0E -> parity bit 1, frame 44 cycles at CLKS_PER_BIT=4.

Source files
------------

// File: rtl/param_alu_tx_pkg.sv
// Shared op codes, serializer state encoding and result sizing for param_alu_tx.
// Defining PARAM_ALU_TX_PARITY_EN adds an even-parity state to the UART frame.
package param_alu_tx_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_NOT = 4'd6;
    localparam logic [3:0] OP_SHL = 4'd7;
    localparam logic [3:0] OP_SHR = 4'd8;
    localparam logic [3:0] OP_CMP = 4'd9;
    localparam logic [3:0] OP_INC = 4'd10;
    localparam logic [3:0] OP_DEC = 4'd11;

`ifdef PARAM_ALU_TX_PARITY_EN
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} ser_state_e;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} ser_state_e;
`endif

    // Bytes needed to carry a 2*width-bit result.
    function automatic int unsigned num_bytes(input int unsigned width);
        return (2 * width + 7) / 8;
    endfunction

endpackage

// File: rtl/param_alu_tx_if.sv
// Operand/command inputs and UART/status outputs of param_alu_tx.
interface param_alu_tx_if #(
    parameter int unsigned WIDTH = 4
) ();
    logic             save_a_n;
    logic             save_b_n;
    logic [WIDTH-1:0] data_input;
    logic [3:0]       op_select;
    logic             start;
    logic             uart_txd;
    logic             uart_busy;
    logic             fifo_full;
    logic             overflow;

    modport master (
        output save_a_n, save_b_n, data_input, op_select, start,
        input  uart_txd, uart_busy, fifo_full, overflow
    );

    modport slave (
        input  save_a_n, save_b_n, data_input, op_select, start,
        output uart_txd, uart_busy, fifo_full, overflow
    );
endinterface

// File: rtl/param_alu_tx_serializer.sv
// UART serializer: pops FIFO entries and sends them LSB byte first, 8N1 frames
// (8E1 when PARAM_ALU_TX_PARITY_EN is defined), back to back with no idle gap.
module alu_uart_serializer
    import param_alu_tx_pkg::*;
#(
    parameter int unsigned WIDTH        = 4,
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fifo_empty,
    input  logic [2*WIDTH-1:0] fifo_head,
    output logic               pop_c,
    output logic               active_d_c,
    output logic               txd
);
    localparam int unsigned NB     = num_bytes(WIDTH);
    localparam int unsigned SH_W   = NB * 8;
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BYTE_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NB - 1);

    ser_state_e        state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [BYTE_W-1:0] byte_q, byte_d;
    logic [SH_W-1:0]   shreg_q, shreg_d;
    logic              parity_q, parity_d;
    logic              txd_q, txd_d;
    logic              bit_done_c;

    assign bit_done_c = (baud_q == BAUD_LAST);

    // txd_d always reflects the level of the state being entered.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        shreg_d  = shreg_q;
        parity_d = parity_q;
        txd_d    = txd_q;
        pop_c    = 1'b0;

        if (state_q != ST_IDLE) begin
            baud_d = bit_done_c ? '0 : baud_q + BAUD_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop_c    = 1'b1;
                    shreg_d  = SH_W'(fifo_head);
                    byte_d   = '0;
                    parity_d = 1'b0;
                    state_d  = ST_START;
                    txd_d    = 1'b0;
                end
            end
            ST_START: begin
                if (bit_done_c) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                    txd_d   = shreg_q[0];
                end
            end
            ST_DATA: begin
                if (bit_done_c) begin
                    shreg_d  = shreg_q >> 1;
                    parity_d = parity_q ^ shreg_q[0];
                    if (bit_q == 3'd7) begin
`ifdef PARAM_ALU_TX_PARITY_EN
                        state_d = ST_PARITY;
                        txd_d   = parity_q ^ shreg_q[0];
`else
                        state_d = ST_STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                        txd_d = shreg_q[1];
                    end
                end
            end
`ifdef PARAM_ALU_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_done_c) begin
                    state_d = ST_STOP;
                    txd_d   = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (bit_done_c) begin
                    if (byte_q != BYTE_LAST) begin
                        byte_d   = byte_q + BYTE_W'(1);
                        parity_d = 1'b0;
                        state_d  = ST_START;
                        txd_d    = 1'b0;
                    end else if (!fifo_empty) begin
                        pop_c    = 1'b1;
                        shreg_d  = SH_W'(fifo_head);
                        byte_d   = '0;
                        parity_d = 1'b0;
                        state_d  = ST_START;
                        txd_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        txd_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    assign active_d_c = (state_d != ST_IDLE);
    assign txd        = txd_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            byte_q   <= '0;
            shreg_q  <= '0;
            parity_q <= 1'b0;
            txd_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            shreg_q  <= shreg_d;
            parity_q <= parity_d;
            txd_q    <= txd_d;
        end
    end

endmodule

// File: rtl/param_alu_tx.sv
// Operand registers, ALU and result FIFO feeding a UART serializer.
// PARAM_ALU_TX_PARITY_EN (optional) enables an even-parity bit per byte.
module param_alu_tx
    import param_alu_tx_pkg::*;
#(
    parameter int unsigned WIDTH        = 4,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic          clk,
    input  logic          reset,
    param_alu_tx_if.slave bus
);
    localparam int unsigned RES_W = 2 * WIDTH;
    localparam int unsigned EXT_W = WIDTH + 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [EXT_W-1:0] diff_c, inc_c, dec_c;
    logic [WIDTH-1:0] not_c, shl_c, shr_c;
    logic [RES_W-1:0] result_c;
    logic [RES_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d, overflow_q, overflow_d, busy_q, busy_d;
    logic             push_c, pop_c, fifo_empty_c, ser_active_d_c, txd;

    // The ALU sees the operands before any same-cycle save.
    always_comb begin
        a_d    = bus.save_a_n ? a_q : bus.data_input;
        b_d    = bus.save_b_n ? b_q : bus.data_input;
        diff_c = {1'b0, a_q} - {1'b0, b_q};
        inc_c  = {1'b0, a_q} + EXT_W'(1);
        dec_c  = {1'b0, a_q} - EXT_W'(1);
        not_c  = ~a_q;
        shl_c  = a_q << b_q;
        shr_c  = a_q >> b_q;
        result_c = '0;
        case (bus.op_select)
            OP_ADD:  result_c = RES_W'(a_q) + RES_W'(b_q);
            OP_SUB:  result_c = RES_W'(diff_c);
            OP_MUL:  result_c = RES_W'(a_q) * RES_W'(b_q);
            OP_AND:  result_c = RES_W'(a_q & b_q);
            OP_OR:   result_c = RES_W'(a_q | b_q);
            OP_XOR:  result_c = RES_W'(a_q ^ b_q);
            OP_NOT:  result_c = RES_W'(not_c);
            OP_SHL:  result_c = RES_W'(shl_c);
            OP_SHR:  result_c = RES_W'(shr_c);
            OP_CMP:  result_c = RES_W'({a_q > b_q, a_q == b_q, a_q < b_q});
            OP_INC:  result_c = RES_W'(inc_c);
            OP_DEC:  result_c = RES_W'(dec_c);
            default: result_c = '0;
        endcase
    end

    // Fullness uses the pre-pop count, so a same-cycle pop never rescues a start.
    always_comb begin
        fifo_empty_c = (count_q == '0);
        push_c       = bus.start && (count_q != CNT_FULL);
        wr_ptr_d     = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d     = pop_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d      = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        full_d       = (count_d == CNT_FULL);
        overflow_d   = overflow_q | (bus.start & ~push_c);
        busy_d       = ser_active_d_c | (count_d != '0);
    end

    alu_uart_serializer #(
        .WIDTH        (WIDTH),
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_ser (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty_c),
        .fifo_head  (mem_q[rd_ptr_q]),
        .pop_c      (pop_c),
        .active_d_c (ser_active_d_c),
        .txd        (txd)
    );

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= result_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q        <= '0;
            b_q        <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.uart_txd  = txd;
    assign bus.uart_busy = busy_q;
    assign bus.fifo_full = full_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_param_alu_tx.sv
// Directed bench for param_alu_tx: a WIDTH=4 and a WIDTH=12 instance at CLKS_PER_BIT=4.
module tb_param_alu_tx;
    localparam int CPB  = 4;
`ifdef PARAM_ALU_TX_PARITY_EN
    localparam int FB   = 11;
`else
    localparam int FB   = 10;
`endif
    localparam int MAXC = 320;
    localparam int NV   = 17;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    logic trace [MAXC];
    int   first_low;
    int   len;

    // a, b, op, expected result byte (hand computed)
    int va  [NV] = '{9, 15, 3, 7, 10, 10, 10, 10, 10, 10, 10, 15, 0, 3, 9, 15, 9};
    int vb  [NV] = '{5, 15, 5, 7, 6, 6, 6, 6, 1, 1, 5, 0, 0, 5, 5, 15, 5};
    int vop [NV] = '{0, 2, 1, 9, 3, 4, 5, 6, 7, 8, 7, 10, 11, 9, 9, 0, 12};
    int vex [NV] = '{'h0E, 'hE1, 'h1E, 'h02, 'h02, 'h0E, 'h0C, 'h05, 'h04, 'h05,
                     'h00, 'h10, 'h1F, 'h01, 'h04, 'h1E, 'h00};
    int ovf_ops [6] = '{0, 1, 3, 4, 5, 6};

    param_alu_tx_if #(.WIDTH(4))  if4 ();
    param_alu_tx_if #(.WIDTH(12)) if12 ();

    param_alu_tx #(.WIDTH(4), .FIFO_DEPTH(4), .CLKS_PER_BIT(CPB)) dut4 (
        .clk(clk), .reset(reset), .bus(if4));
    param_alu_tx #(.WIDTH(12), .FIFO_DEPTH(2), .CLKS_PER_BIT(CPB)) dut12 (
        .clk(clk), .reset(reset), .bus(if12));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input bit big, input logic sa_n, input logic sb_n,
                          input int d, input int op, input logic st);
        if (big) begin
            if12.save_a_n = sa_n; if12.save_b_n = sb_n; if12.data_input = 12'(d);
            if12.op_select = 4'(op); if12.start = st;
        end else begin
            if4.save_a_n = sa_n; if4.save_b_n = sb_n; if4.data_input = 4'(d);
            if4.op_select = 4'(op); if4.start = st;
        end
    endtask

    task automatic idle_in();
        set_in(1'b0, 1'b1, 1'b1, 0, 0, 1'b0);
        set_in(1'b1, 1'b1, 1'b1, 0, 0, 1'b0);
    endtask

    task automatic step(input bit big, input logic sa_n, input logic sb_n,
                        input int d, input int op, input logic st);
        set_in(big, sa_n, sb_n, d, op, st);
        @(posedge clk);
        #1 idle_in();
    endtask

    // Records txd at each falling edge until busy drops after the first start bit.
    task automatic capture(input bit big);
        logic t, b;
        first_low = -1;
        len = -1;
        for (int i = 0; i < MAXC; i++) trace[i] = 1'b1;
        for (int c = 0; c < MAXC; c++) begin
            @(negedge clk);
            t = big ? if12.uart_txd : if4.uart_txd;
            b = big ? if12.uart_busy : if4.uart_busy;
            trace[c] = t;
            if (first_low < 0 && t == 1'b0) first_low = c;
            if (first_low >= 0 && b == 1'b0) begin
                len = c - first_low;
                break;
            end
        end
        if (first_low < 0) first_low = 0;
    endtask

    function automatic int rx_byte(input int base);
        int v = 0;
        for (int i = 0; i < 8; i++) if (trace[base + (1 + i) * CPB + 1] == 1'b1) v |= (1 << i);
        return v;
    endfunction

    function automatic int frame_ok(input int base);
        return (trace[base + 1] == 1'b0 && trace[base + (FB - 1) * CPB + 1] == 1'b1) ? 1 : 0;
    endfunction

    task automatic check_result(input string tag, input int nb, input logic [63:0] exp);
        logic [7:0] eb;
        int base;
        check({tag, " latency"}, first_low, 1);
        check({tag, " length"}, len, nb * FB * CPB);
        for (int j = 0; j < nb; j++) begin
            base = first_low + j * FB * CPB;
            eb = exp[8 * j +: 8];
            check($sformatf("%s byte%0d", tag, j), rx_byte(base), 32'(eb));
            check($sformatf("%s frame%0d", tag, j), frame_ok(base), 1);
`ifdef PARAM_ALU_TX_PARITY_EN
            check($sformatf("%s parity%0d", tag, j), 32'(trace[base + 9 * CPB + 1]), 32'(^eb));
`endif
        end
    endtask

    initial begin
        int lows, busys;
        reset = 1'b1;
        idle_in();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset txd4", if4.uart_txd, 1);
        check("reset busy4", if4.uart_busy, 0);
        check("reset full4", if4.fifo_full, 0);
        check("reset ovf4", if4.overflow, 0);
        check("reset txd12", if12.uart_txd, 1);
        check("reset busy12", if12.uart_busy, 0);

        // Equal operands are loaded through both saves in the same cycle.
        for (int i = 0; i < NV; i++) begin
            if (va[i] == vb[i]) begin
                step(1'b0, 1'b0, 1'b0, va[i], 0, 1'b0);
            end else begin
                step(1'b0, 1'b0, 1'b1, va[i], 0, 1'b0);
                step(1'b0, 1'b1, 1'b0, vb[i], 0, 1'b0);
            end
            step(1'b0, 1'b1, 1'b1, 0, vop[i], 1'b1);
            capture(1'b0);
            check_result($sformatf("w4 op%0d a%0d b%0d", vop[i], va[i], vb[i]), 1, 64'(vex[i]));
        end

        // A=9, B=5: start with a simultaneous save of A uses the old A.
        step(1'b0, 1'b0, 1'b1, 15, 1, 1'b1);
        capture(1'b0);
        check_result("preload sub", 1, 64'h04);
        step(1'b0, 1'b1, 1'b1, 0, 0, 1'b1);
        capture(1'b0);
        check_result("new A add", 1, 64'h14);

        step(1'b1, 1'b0, 1'b0, 'hFFF, 0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 0, 2, 1'b1);
        capture(1'b1);
        check_result("w12 mul", 3, 64'hFFE001);

        // Six back-to-back starts into a depth-4 FIFO.
        step(1'b0, 1'b0, 1'b1, 9, 0, 1'b0);
        set_in(1'b0, 1'b1, 1'b1, 0, ovf_ops[0], 1'b1);
        fork
            begin
                for (int k = 1; k < 6; k++) begin
                    @(posedge clk);
                    #1 set_in(1'b0, 1'b1, 1'b1, 0, ovf_ops[k], 1'b1);
                end
                @(posedge clk);
                #1 idle_in();
                @(negedge clk);
                check("ovf flag", if4.overflow, 1);
                check("ovf full", if4.fifo_full, 1);
            end
            begin
                @(posedge clk);
                capture(1'b0);
            end
        join
        check_result("overflow burst", 5, 64'h0C0D01040E);
        check("ovf sticky", if4.overflow, 1);

        // Reset in the middle of a data bit with a second result queued.
        step(1'b0, 1'b1, 1'b1, 0, 0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 0, 0, 1'b1);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        set_in(1'b0, 1'b1, 1'b1, 0, 0, 1'b1);
        @(posedge clk);
        #1 reset = 1'b0;
        idle_in();
        @(negedge clk);
        check("midrst txd", if4.uart_txd, 1);
        check("midrst busy", if4.uart_busy, 0);
        check("midrst ovf", if4.overflow, 0);
        check("midrst full", if4.fifo_full, 0);
        lows = 0;
        busys = 0;
        repeat (120) begin
            @(negedge clk);
            if (if4.uart_txd !== 1'b1) lows++;
            if (if4.uart_busy !== 1'b0) busys++;
        end
        check("post-reset txd lows", lows, 0);
        check("post-reset busy", busys, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
